mult32_seq: RTL

MULT32_SEQ -- requirements
Module: mult32_seq

---
 rtl/mult32_seq_pkg.sv | 23 ++
 rtl/mult32_seq_alu32.sv | 38 +++
 rtl/mult32_seq.sv | 96 +++++++++
 3 files changed

// File: rtl/mult32_seq_pkg.sv
// Shared definitions for the sequential 32x32 multiplier: FSM encoding,
// ALU operation codes and the iteration count.
package mult32_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_NOR = 3'b111;

  localparam int ITER  = 32;
  localparam int CNT_W = 5;

endpackage

// File: rtl/mult32_seq_alu32.sv
// 32-bit combinational ALU shared with the rest of the datapath; the
// multiplier only ever drives it with ALU_ADD.
module alu32
  import mult32_seq_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  op_i,
  output logic [31:0] result_o,
  output logic        overflow_o,
  output logic        zero_o
);

  always_comb begin
    result_o   = 32'd0;
    overflow_o = 1'b0;
    case (op_i)
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_ADD: begin
        result_o   = a_i + b_i;
        overflow_o = (a_i[31] == b_i[31]) && (result_o[31] != a_i[31]);
      end
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_SUB: begin
        result_o   = a_i - b_i;
        overflow_o = (a_i[31] != b_i[31]) && (result_o[31] != a_i[31]);
      end
      ALU_SRA: result_o = $signed(a_i) >>> b_i[4:0];
      ALU_SLL: result_o = a_i << b_i[4:0];
      ALU_NOR: result_o = ~(a_i | b_i);
      default: result_o = 32'd0;
    endcase
  end

  assign zero_o = (result_o == 32'd0);

endmodule

// File: rtl/mult32_seq.sv
// Sequential unsigned 32x32 -> 64 shift-add multiplier: one accumulator bit
// per clock, 32 steps, then a single-cycle done pulse.
module mult32_seq
  import mult32_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product,
  output logic        zero
);

  state_e            state_q;
  logic [CNT_W-1:0]  count_q;
  logic [31:0]       mcand_q;
  logic [63:0]       acc_q;
  logic [63:0]       acc_d;
  logic              busy_q;
  logic              done_q;

  logic [31:0]       aluSum;
  logic              unusedAluOverflow;
  logic              unusedAluZero;
  logic [31:0]       stepSum;
  logic              stepCarry;

  alu32 u_alu (
    .a_i        (acc_q[63:32]),
    .b_i        (mcand_q),
    .op_i       (ALU_ADD),
    .result_o   (aluSum),
    .overflow_o (unusedAluOverflow),
    .zero_o     (unusedAluZero)
  );

  // Carry out of the 32-bit add is rebuilt from the operand and sum MSBs,
  // so the accumulator keeps 33 significant upper bits before shifting.
  always_comb begin
    stepSum   = acc_q[0] ? aluSum : acc_q[63:32];
    stepCarry = acc_q[0] & ((acc_q[63] & mcand_q[31]) |
                            ((acc_q[63] ^ mcand_q[31]) & ~aluSum[31]));
    acc_d     = {stepCarry, stepSum, acc_q[31:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q <= a;
            acc_q   <= {32'd0, b};
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          if (count_q == CNT_W'(ITER - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = acc_q;
  assign zero    = ~|acc_q;

endmodule
